debounce_sync: RTL and testbench
================================

# debounce_sync

Input conditioner for raw, asynchronous board inputs (pushbuttons, slide switches). It synchronizes `din` into the `clk` domain with a two-flop synchronizer, then accepts a level change only after it has held for `N_STABLE` consecutive cycles. It outputs the clean level plus one-cycle rise/fall pulses. It sits directly upstream of the flip-flop, register and counter stages, driving their data/enable inputs.

## Interface
- `N_STABLE`, default 16: consecutive sampled cycles a new level must hold before it is committed; legal range 2..65535.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `din`  in  1: raw asynchronous input; may bounce or glitch.
- `dout`  out  1: debounced, synchronized level.
- `rise`  out  1: single-cycle pulse when `dout` goes 0→1.
- `fall`  out  1: single-cycle pulse when `dout` goes 1→0.

## Operation
- Synchronizer: `s1 <= din`, `s2 <= s1`. The FSM sees only `s2`.
- Counter `cnt`: width `$clog2(N_STABLE)`. No wrap: it is compared against `N_STABLE-1` and never exceeds it.
- FSM states and transitions:
  - IDLE_LO (`dout`=0):
    - `s2`=1 → WAIT_HI, `cnt`<=1.
    - Otherwise stay.
  - WAIT_HI (`dout`=0):
    - `s2`=0 → IDLE_LO, `cnt`<=0 (glitch rejected).
    - `s2`=1 and `cnt`==N_STABLE-1 → IDLE_HI, `dout`<=1, `rise`<=1.
    - `s2`=1 otherwise → `cnt`<=`cnt`+1.
  - IDLE_HI (`dout`=1):
    - `s2`=0 → WAIT_LO, `cnt`<=1.
    - Otherwise stay.
  - WAIT_LO (`dout`=1): mirror of WAIT_HI.
    - `s2`=1 → IDLE_HI, `cnt`<=0.
    - `s2`=0 and `cnt`==N_STABLE-1 → IDLE_LO, `dout`<=0, `fall`<=1.
    - `s2`=0 otherwise → `cnt`<=`cnt`+1.
- `rise`/`fall` are registered. Each is high for exactly one cycle per committed transition and is never high in the same cycle as the other.
- Acceptance boundary:
  - A level held for exactly N_STABLE cycles at `s2` is accepted.
  - A level held for N_STABLE-1 cycles is rejected.
  - Any opposite sample during WAIT_* restarts the qualification from the stable state.
- Reset (`rst_n`=0 at an edge), from any state including mid-WAIT:
  - `s1`, `s2`, `cnt` <= 0.
  - `dout`, `rise`, `fall` <= 0.
  - State <= IDLE_LO.
- After reset release with `din`=1, the block qualifies the high level normally; `rise` then fires. This is intended: downstream logic sees a clean power-on edge.

## Timing
- Edge numbering: "edge 0" is the first rising edge at which `din` is sampled at its new, stable value.
  - `s2` holds the new value after edge 1.
  - The FSM leaves IDLE at edge 2.
  - `dout`/`rise` (or `fall`) update after edge N_STABLE+1.
- Latency `din` → `dout` = N_STABLE+2 clock edges. For N_STABLE=16 at 12 MHz this is ≈1.5 µs.
- `rise`/`fall` deassert after edge N_STABLE+2.
- No combinational path from `din` to any output. All outputs are registered.
- `din` needs no setup/hold relationship to `clk`. Metastability is confined to `s1`.

## Structure
- Shared package `debounce_pkg`:
  - State encoding constants `ST_IDLE_LO`=2'd0, `ST_WAIT_HI`=2'd1, `ST_IDLE_HI`=2'd2, `ST_WAIT_LO`=2'd3.
  - Default `N_STABLE`.
- Natural sub-module `sync_2ff`: `clk`, `rst_n`, `d`, `q`. It is reused by later stages that cross asynchronous inputs.
- Top level holds the FSM, `cnt` and the pulse registers.

## Test plan
All scenarios use N_STABLE=4; edges are numbered as in Timing.
- Reset hold: `rst_n`=0 for 3 edges with `din`=1 → `dout`=`rise`=`fall`=0 throughout. After release, `din` held 1 → `dout`=1 and `rise`=1 after edge 5; `rise`=0 after edge 6.
- Clean edges: `din` 0→1 held → single `rise` after edge 5. Later `din` 1→0 held → single `fall` after edge 5 of that transition, `dout`=0.
- Glitch reject: from IDLE_LO, `din`=1 for exactly 3 cycles then 0 → `dout` stays 0, no `rise`/`fall`, FSM back in IDLE_LO.
- Exact boundary: `din`=1 for exactly 4 cycles then 0 → `dout` goes 1 with one `rise`, then returns to 0 with one `fall` 4 cycles after the 0 is seen at `s2`.
- Bounce: `din` toggles 1,0,1,0,1 on consecutive edges then stays 1 → exactly one `rise`, 5 edges after the final 1 is sampled. No `fall` at any point.
- Reset mid-qualification: enter WAIT_HI (`cnt`=2), assert `rst_n`=0 for 1 edge → `cnt`=0, IDLE_LO, no `rise`. A new full qualification is required afterwards.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the input debouncer
package debounce_pkg;

    localparam int unsigned N_STABLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_IDLE_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } deb_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // s1_q is the only flop allowed to go metastable; nothing else reads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronize and debounce a raw board input, emit edge pulses
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned N_STABLE = N_STABLE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W   = (N_STABLE > 1) ? $clog2(N_STABLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s2;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (s2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt counts samples of the candidate level already seen, so entering WAIT loads 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_IDLE_LO: begin
                if (s2) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_HI: begin
                if (!s2) begin
                    state_d = ST_IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE_HI: begin
                if (!s2) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (s2) begin
                    state_d = ST_IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync against a sample-history model
module tb_debounce_sync;

    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
    logic din;
    logic dout;
    logic rise;
    logic fall;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the synchronizer is a 2-sample delay; a level is committed once the last
    // N delayed samples all disagree with the current output.
    logic m_s1, m_s2, m_dout, m_rise, m_fall;
    logic hist[$];

    debounce_sync #(.N_STABLE(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic d, input logic r);
        bit all_opp;
        if (!r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            hist.delete();
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            all_opp = (hist.size() == N);
            foreach (hist[i]) if (hist[i] == m_dout) all_opp = 1'b0;
            if (all_opp) begin
                m_dout = ~m_dout;
                if (m_dout) m_rise = 1'b1;
                else        m_fall = 1'b1;
                hist.delete();
            end
            m_s2 = m_s1;
            m_s1 = d;
        end
    endtask

    // Inputs change just after a negedge; outputs are compared at the following negedge.
    task automatic cycle(input logic d, input logic r);
        din   = d;
        rst_n = r;
        model_edge(d, r);
        @(negedge clk);
        check_eq("dout", dout, m_dout);
        check_eq("rise", rise, m_rise);
        check_eq("fall", fall, m_fall);
        check_eq("excl", rise & fall, 1'b0);
    endtask

    task automatic hold(input logic d, input int n);
        for (int i = 0; i < n; i++) cycle(d, 1'b1);
    endtask

    initial begin
        int lat;
        int pulses;
        din   = 1'b0;
        rst_n = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0;

        // Reset hold with din high, then power-on qualification.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check_eq("rst_dout", dout, 1'b0);
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1);
            if (rise && lat == 99) lat = i;
        end
        check_eq("por_rise_lat", lat, 5);

        // Clean falling edge, measured from the first low sample.
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1);
            if (fall && lat == 99) lat = i;
        end
        check_eq("fall_lat", lat, 5);
        check_eq("fall_dout", dout, 1'b0);

        // Clean rising edge.
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1);
            if (rise && lat == 99) lat = i;
        end
        check_eq("rise_lat", lat, 5);
        hold(1'b0, 12);

        // Glitch of N-1 cycles is rejected.
        pulses = 0;
        for (int i = 0; i < 3; i++) begin cycle(1'b1, 1'b1); pulses += int'(rise) + int'(fall); end
        for (int i = 0; i < 12; i++) begin cycle(1'b0, 1'b1); pulses += int'(rise) + int'(fall); end
        check_eq("glitch_pulses", pulses, 0);
        check_eq("glitch_dout", dout, 1'b0);

        // Exactly N cycles is accepted, then falls back.
        pulses = 0;
        for (int i = 0; i < 4; i++) begin cycle(1'b1, 1'b1); pulses += int'(rise); end
        for (int i = 0; i < 12; i++) begin cycle(1'b0, 1'b1); pulses += int'(rise) + 2 * int'(fall); end
        check_eq("exact_pulses", pulses, 3);

        // Bounce then settle high: one rise, no fall.
        pulses = 0;
        cycle(1'b1, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1); cycle(1'b0, 1'b1);
        lat = 99;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b1);
            pulses += int'(rise) + 2 * int'(fall);
            if (rise && lat == 99) lat = i;
        end
        check_eq("bounce_pulses", pulses, 1);
        check_eq("bounce_lat", lat, 5);
        hold(1'b0, 12);

        // Reset mid-qualification forces a fresh full qualification.
        hold(1'b1, 4);
        cycle(1'b1, 1'b0);
        lat = 99;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b1);
            if (rise && lat == 99) lat = i;
        end
        check_eq("rst_mid_lat", lat, 5);

        // Random bursts with occasional resets.
        for (int seg = 0; seg < 600; seg++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(N, N + 3)) : int'($urandom_range(1, N + 1));
            if ($urandom_range(0, 59) == 0) cycle(lv, 1'b0);
            else hold(lv, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
